mxalu_seq: RTL and testbench
============================

MXALU_SEQ -- requirements
Module: mxalu_seq

Interface
REQ-001 SHALL have parameter NBYTES, default 4, maximum operand bytes; legal range 1..4.
REQ-002 SHALL have port clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active low.
REQ-004 SHALL have port req_valid  in  1  operation request.
REQ-005 SHALL have port req_ready  out  1  request accepted when req_valid and req_ready are both high on a clock edge.
REQ-006 SHALL have port op_a  in  8*NBYTES  operand A.
REQ-007 SHALL have port op_b  in  8*NBYTES  operand B.
REQ-008 SHALL have port op_s  in  4  181 function select.
REQ-009 SHALL have port op_m  in  1  mode (1 = logic, 0 = arithmetic).
REQ-010 SHALL have port op_cin_n  in  1  carry-in to byte 0, active low.
REQ-011 SHALL have port op_len  in  2  active bytes minus 1.
REQ-012 SHALL have port alu_a  out  8  byte of A to the 8-bit ALU slice.
REQ-013 SHALL have port alu_b  out  8  byte of B to the 8-bit ALU slice.
REQ-014 SHALL have port alu_s  out  4  select to the ALU slice.
REQ-015 SHALL have port alu_m  out  1  mode to the ALU slice.
REQ-016 SHALL have port alu_cn_n  out  1  carry-in to the ALU slice, active low.
REQ-017 SHALL have port alu_f  in  8  slice result, combinational from alu_* outputs.
REQ-018 SHALL have port alu_cn8_n  in  1  slice carry-out, active low.
REQ-019 SHALL have port alu_a_b  in  1  slice A=B output.
REQ-020 SHALL have port rsp_valid  out  1  result valid.
REQ-021 SHALL have port rsp_ready  in  1  result consumed when rsp_valid and rsp_ready are both high.
REQ-022 SHALL have port rsp_f  out  8*NBYTES  result; bytes above op_len are zero.
REQ-023 SHALL have port rsp_cout_n  out  1  carry-out of the last active byte, active low.
REQ-024 SHALL have port rsp_eq  out  1  AND of alu_a_b over all active bytes.
REQ-025 SHALL have port rsp_zero  out  1  all active result bytes zero.

Function
REQ-026 SHALL implement the FSM IDLE -> RUN on accept; RUN -> DONE after the last active byte is captured; DONE -> IDLE on rsp handshake.
REQ-027 SHALL drive req_ready high only in IDLE; a request is never accepted in the cycle DONE exits.
REQ-028 SHALL, on accept, latch op_a, op_b, op_s, op_m, op_len and op_cin_n, clear byte index k to 0, and clear the result.
REQ-029 SHALL, in RUN, present byte k of the latched A and B on alu_a and alu_b, and the latched select and mode on alu_s and alu_m.
REQ-030 SHALL drive alu_cn_n in RUN as follows: for k=0, the latched op_cin_n; for k>0, alu_cn8_n registered in the previous cycle.
REQ-031 SHALL, on each RUN edge, store alu_f into rsp_f byte k, register alu_cn8_n, AND alu_a_b into the eq accumulator, and increment k.
REQ-032 SHALL make the latency from the accept edge to rsp_valid high exactly op_len+2 cycles (one per byte plus one to enter DONE).
REQ-033 SHALL iterate bytes in logic mode (op_m=1) exactly as in arithmetic mode; in logic mode rsp_cout_n is whatever the slice reports.
REQ-034 SHALL clamp op_len values greater than NBYTES-1 to NBYTES-1.
REQ-035 SHALL hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
REQ-036 SHALL, outside RUN, drive alu_a, alu_b, alu_s and alu_m to 0 and alu_cn_n to 1.

Reset
REQ-037 SHALL, on rst_n low, asynchronously enter IDLE with k=0, rsp_valid=0, rsp_f=0, rsp_cout_n=1, rsp_eq=0, rsp_zero=0, and req_ready=1.
REQ-038 SHALL, on reset mid-RUN or mid-DONE, abandon the operation with no response produced; the first request after reset is processed normally.

Configuration
REQ-039 SHALL, with macro MXALU_SEQ_ZERO_EN defined, compute rsp_zero as the NOR of all active result bytes; without the macro, rsp_zero SHALL be tied to 0 and the zero logic SHALL be absent.

Verification
REQ-040 SHALL cover a 16-bit add: op_len=1, s=1001, m=0, cin_n=1, A=0x00FF, B=0x0001 -> rsp_f=0x0100, rsp_cout_n=1, rsp_valid 3 cycles after accept.
REQ-041 SHALL cover a 32-bit carry wrap: op_len=3, add, A=0xFFFFFFFF, B=0x00000001 -> rsp_f=0, rsp_cout_n=0, rsp_zero=1 (rsp_zero=0 when the macro is off).
REQ-042 SHALL cover a 16-bit subtract with equality: s=0110, m=0, cin_n=0, A=B=0x5A5A -> rsp_f=0x0000, rsp_eq=1; repeat with B=0x5A5B -> rsp_eq=0.
REQ-043 SHALL cover an 8-bit logic XOR: op_len=0, s=0110, m=1, A=0xF0, B=0x3C -> rsp_f low byte 0xCC, upper bytes 0, latency 2.
REQ-044 SHALL cover backpressure: rsp_ready held low 5 cycles -> rsp_* stable, req_ready low, and a new req_valid is not accepted until the cycle after the rsp handshake.
REQ-045 SHALL cover reset mid-RUN: rst_n pulsed low at k=1 of a 4-byte add -> immediate IDLE, rsp_valid never asserted, next request returns the correct result.

Source files
------------

// File: rtl/mxalu_seq_if.sv
// mxalu_seq bus: request, response and 8-bit ALU slice signals.
// slave is the sequencer side, master the requester/slice side.
interface mxalu_seq_if #(
  parameter int NBYTES = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic [8*NBYTES-1:0]   op_a;
  logic [8*NBYTES-1:0]   op_b;
  logic [3:0]            op_s;
  logic                  op_m;
  logic                  op_cin_n;
  logic [1:0]            op_len;

  logic [7:0]            alu_a;
  logic [7:0]            alu_b;
  logic [3:0]            alu_s;
  logic                  alu_m;
  logic                  alu_cn_n;
  logic [7:0]            alu_f;
  logic                  alu_cn8_n;
  logic                  alu_a_b;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [8*NBYTES-1:0]   rsp_f;
  logic                  rsp_cout_n;
  logic                  rsp_eq;
  logic                  rsp_zero;

  modport slave (
    input  req_valid, op_a, op_b, op_s,
    input  op_m, op_cin_n, op_len,
    output req_ready,
    output alu_a, alu_b, alu_s, alu_m,
    output alu_cn_n,
    input  alu_f, alu_cn8_n, alu_a_b,
    output rsp_valid, rsp_f, rsp_cout_n,
    output rsp_eq, rsp_zero,
    input  rsp_ready
  );

  modport master (
    output req_valid, op_a, op_b, op_s,
    output op_m, op_cin_n, op_len,
    input  req_ready,
    input  alu_a, alu_b, alu_s, alu_m,
    input  alu_cn_n,
    output alu_f, alu_cn8_n, alu_a_b,
    input  rsp_valid, rsp_f, rsp_cout_n,
    input  rsp_eq, rsp_zero,
    output rsp_ready
  );
endinterface

// File: rtl/mxalu_seq.sv
// Multi-byte ALU sequencer driving one external 8-bit 181 slice.
// Optional zero flag: define MXALU_SEQ_ZERO_EN.
module mxalu_seq #(
  parameter int NBYTES = 4
) (
  input logic        clk,
  input logic        rst_n,
  mxalu_seq_if.slave bus
);

  localparam int         W    = 8 * NBYTES;
  localparam logic [1:0] LMAX = 2'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e       state_q;
  state_e       state_d;

  logic [W-1:0] a_q;
  logic [W-1:0] b_q;
  logic [W-1:0] f_q;
  logic [W-1:0] f_nxt;
  logic [3:0]   s_q;
  logic         m_q;
  logic         cin_q;
  logic         cy_q;
  logic         eq_q;
  logic [1:0]   len_q;
  logic [2:0]   k_q;

  logic         accept;
  logic         cap;
  logic         last;
  logic [1:0]   len_in;
  logic [4:0]   bofs;

  // Oversized lengths fold to the widest operand.
  assign len_in = (bus.op_len > LMAX) ? LMAX : bus.op_len;

  // k runs one past the last byte: that cycle only enters DONE.
  assign cap  = (k_q <= {1'b0, len_q});
  assign last = cap && (k_q[1:0] == len_q);
  assign bofs = {k_q[1:0], 3'b000};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and request handshake.
  always_comb begin
    state_d       = state_q;
    bus.req_ready = 1'b0;
    accept        = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!cap) state_d = DONE;
      end
      DONE: begin
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slice drive: current byte while capturing, idle values otherwise.
  always_comb begin
    bus.alu_a    = 8'h00;
    bus.alu_b    = 8'h00;
    bus.alu_s    = 4'h0;
    bus.alu_m    = 1'b0;
    bus.alu_cn_n = 1'b1;
    if (state_q == RUN && cap) begin
      bus.alu_a    = a_q[bofs +: 8];
      bus.alu_b    = b_q[bofs +: 8];
      bus.alu_s    = s_q;
      bus.alu_m    = m_q;
      bus.alu_cn_n = (k_q == 3'd0) ? cin_q : cy_q;
    end
  end

  // Result with the slice output merged into byte k.
  always_comb begin
    f_nxt              = f_q;
    f_nxt[bofs +: 8]   = bus.alu_f;
  end

  // Operand latch and per-byte result accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= 4'h0;
      m_q   <= 1'b0;
      cin_q <= 1'b1;
      len_q <= 2'd0;
      k_q   <= 3'd0;
      f_q   <= '0;
      cy_q  <= 1'b1;
      eq_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.op_a;
      b_q   <= bus.op_b;
      s_q   <= bus.op_s;
      m_q   <= bus.op_m;
      cin_q <= bus.op_cin_n;
      len_q <= len_in;
      k_q   <= 3'd0;
      f_q   <= '0;
      cy_q  <= 1'b1;
      eq_q  <= 1'b1;
    end else if (state_q == RUN && cap) begin
      f_q   <= f_nxt;
      cy_q  <= bus.alu_cn8_n;
      eq_q  <= eq_q & bus.alu_a_b;
      k_q   <= k_q + 3'd1;
    end
  end

`ifdef MXALU_SEQ_ZERO_EN
  logic zero_q;

  // Zero flag taken from the completed result at the last byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      zero_q <= 1'b0;
    else if (accept) zero_q <= 1'b0;
    else if (state_q == RUN && last)
      zero_q <= ~|f_nxt;
  end

  assign bus.rsp_zero = zero_q;
`else
  assign bus.rsp_zero = 1'b0;
`endif

  assign bus.rsp_valid  = (state_q == DONE);
  assign bus.rsp_f      = f_q;
  assign bus.rsp_cout_n = cy_q;
  assign bus.rsp_eq     = eq_q;

endmodule

// File: tb/tb_mxalu_seq.sv
// Bench for mxalu_seq: 181 slice model, vector table,
// hand sequences and randomized ops against a full-width model.
module tb_mxalu_seq;

  localparam int NB = 4;
`ifdef MXALU_SEQ_ZERO_EN
  localparam bit ZEN = 1'b1;
`else
  localparam bit ZEN = 1'b0;
`endif

  typedef struct {
    string       nm;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  s;
    logic        m;
    logic        cin_n;
    logic [1:0]  len;
    logic [31:0] ef;
    logic        ecout;
    logic        eeq;
    logic        ezero;
    int          elat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   ncmp;
  int   nfail;

  mxalu_seq_if #(.NBYTES(NB)) bus ();

  mxalu_seq #(.NBYTES(NB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 181 function over nb bits (active-high data), returns {cout_n, f}.
  function automatic logic [32:0] f181(
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] s, input logic m,
    input logic cin_n, input int nb);
    logic [31:0] mask, x, y, l;
    logic [32:0] sum;
    logic        cy;
    mask = (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
    case (s)
      4'd0:  begin x = a;      y = 0;       l = ~a;       end
      4'd1:  begin x = a | b;  y = 0;       l = ~(a | b); end
      4'd2:  begin x = a | ~b; y = 0;       l = ~a & b;   end
      4'd3:  begin x = '1;     y = 0;       l = 0;        end
      4'd4:  begin x = a;      y = a & ~b;  l = ~(a & b); end
      4'd5:  begin x = a | b;  y = a & ~b;  l = ~b;       end
      4'd6:  begin x = a;      y = ~b;      l = a ^ b;    end
      4'd7:  begin x = a & ~b; y = '1;      l = a & ~b;   end
      4'd8:  begin x = a;      y = a & b;   l = ~a | b;   end
      4'd9:  begin x = a;      y = b;       l = ~(a ^ b); end
      4'd10: begin x = a | ~b; y = a & b;   l = b;        end
      4'd11: begin x = a & b;  y = '1;      l = a & b;    end
      4'd12: begin x = a;      y = a;       l = '1;       end
      4'd13: begin x = a | b;  y = a;       l = a | ~b;   end
      4'd14: begin x = a | ~b; y = a;       l = a | b;    end
      default: begin x = a;    y = '1;      l = a;        end
    endcase
    x   = x & mask;
    y   = y & mask;
    sum = {1'b0, x} + {1'b0, y} + {32'd0, ~cin_n};
    cy  = sum[nb];
    return {~cy, (m ? l : sum[31:0]) & mask};
  endfunction

  // External 8-bit slice.
  always_comb begin
    logic [32:0] r;
    r = f181({24'd0, bus.alu_a}, {24'd0, bus.alu_b},
             bus.alu_s, bus.alu_m, bus.alu_cn_n, 8);
    bus.alu_f     = r[7:0];
    bus.alu_cn8_n = r[32];
    bus.alu_a_b   = (bus.alu_a == bus.alu_b);
  end

  // Whole-operand reference.
  function automatic vec_t model(
    input logic [31:0] a, input logic [31:0] b,
    input logic [3:0] s, input logic m,
    input logic cin_n, input logic [1:0] len);
    vec_t        v;
    int          l;
    int          nb;
    logic [31:0] mask;
    logic [32:0] r;
    l    = (int'(len) > NB - 1) ? NB - 1 : int'(len);
    nb   = 8 * (l + 1);
    mask = (nb >= 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
    r    = f181(a, b, s, m, cin_n, nb);
    v.nm = "rand";
    v.a = a; v.b = b; v.s = s; v.m = m;
    v.cin_n = cin_n; v.len = len;
    v.ef    = r[31:0];
    v.ecout = r[32];
    v.eeq   = ((a & mask) == (b & mask));
    v.ezero = ZEN && (r[31:0] == 32'd0);
    v.elat  = l + 2;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input int hold,
                        input bit pend);
    int n;
    int lat;
    bit bad;
    bit ok;
    @(negedge clk);
    bus.op_a     = v.a;
    bus.op_b     = v.b;
    bus.op_s     = v.s;
    bus.op_m     = v.m;
    bus.op_cin_n = v.cin_n;
    bus.op_len   = v.len;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({v.nm, " accept"}, 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    bad = 1'b0;
    do begin
      if (bus.req_ready) bad = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.rsp_valid && lat < 20);
    chk({v.nm, " latency"}, 32'(lat), 32'(v.elat));
    chk({v.nm, " busy"}, 32'(bad), 32'd0);
    chk({v.nm, " f"}, bus.rsp_f, v.ef);
    chk({v.nm, " cout_n"}, 32'(bus.rsp_cout_n), 32'(v.ecout));
    chk({v.nm, " eq"}, 32'(bus.rsp_eq), 32'(v.eeq));
    chk({v.nm, " zero"}, 32'(bus.rsp_zero), 32'(v.ezero));
    for (int h = 0; h < hold; h++) begin
      bus.rsp_ready = 1'b0;
      if (pend) bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      ok = bus.rsp_valid && !bus.req_ready &&
           bus.rsp_f == v.ef && bus.rsp_eq == v.eeq &&
           bus.rsp_cout_n == v.ecout &&
           bus.rsp_zero == v.ezero;
      chk({v.nm, " hold"}, 32'(ok), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    ok = !bus.rsp_valid && bus.req_ready;
    chk({v.nm, " release"}, 32'(ok), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[8];
    vec_t v;
    bit   seen;
    ncmp  = 0;
    nfail = 0;

    tab[0] = '{"add16", 32'h0000_00FF, 32'h0000_0001, 4'b1001,
               1'b0, 1'b1, 2'd1, 32'h0000_0100, 1'b1, 1'b0,
               1'b0, 3};
    tab[1] = '{"wrap32", 32'hFFFF_FFFF, 32'h0000_0001, 4'b1001,
               1'b0, 1'b1, 2'd3, 32'h0, 1'b0, 1'b0, ZEN, 5};
    tab[2] = '{"sub_eq", 32'h0000_5A5A, 32'h0000_5A5A, 4'b0110,
               1'b0, 1'b0, 2'd1, 32'h0, 1'b0, 1'b1, ZEN, 3};
    tab[3] = '{"sub_ne", 32'h0000_5A5A, 32'h0000_5A5B, 4'b0110,
               1'b0, 1'b0, 2'd1, 32'h0000_FFFF, 1'b1, 1'b0,
               1'b0, 3};
    tab[4] = '{"xor8", 32'h1234_56F0, 32'hABCD_EF3C, 4'b0110,
               1'b1, 1'b1, 2'd0, 32'h0000_00CC, 1'b0, 1'b0,
               1'b0, 2};
    tab[5] = '{"and32", 32'hFFFF_0000, 32'h0F0F_0F0F, 4'b1011,
               1'b1, 1'b1, 2'd3, 32'h0F0F_0000, 1'b0, 1'b0,
               1'b0, 5};
    tab[6] = '{"xnor24", 32'h11AB_CDEF, 32'h22AB_CDEF, 4'b1001,
               1'b1, 1'b1, 2'd2, 32'h00FF_FFFF, 1'b0, 1'b1,
               1'b0, 4};
    tab[7] = '{"cin8", 32'h0000_00FF, 32'h0000_0000, 4'b1001,
               1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 1'b0, ZEN, 2};

    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.op_a = '0; bus.op_b = '0; bus.op_s = 4'h0;
    bus.op_m = 1'b0; bus.op_cin_n = 1'b1; bus.op_len = 2'd0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst rsp_f", bus.rsp_f, 32'd0);
    chk("rst cout_n", 32'(bus.rsp_cout_n), 32'd1);
    chk("rst eq", 32'(bus.rsp_eq), 32'd0);
    chk("rst zero", 32'(bus.rsp_zero), 32'd0);
    chk("rst alu_cn_n", 32'(bus.alu_cn_n), 32'd1);
    chk("rst alu_a", 32'(bus.alu_a), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_op(tab[i], 0, 1'b0);

    // Backpressure, with a request pending through the stall.
    run_op(tab[0], 5, 1'b1);
    run_op(tab[0], 0, 1'b0);

    // Reset while byte 1 of a 4-byte add is on the slice.
    @(negedge clk);
    bus.op_a = 32'h1234_5678; bus.op_b = 32'h1111_1111;
    bus.op_s = 4'b1001; bus.op_m = 1'b0;
    bus.op_cin_n = 1'b1; bus.op_len = 2'd3;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mid alu_a k1", 32'(bus.alu_a), 32'h56);
    rst_n = 1'b0;
    #1;
    chk("mid rst idle", 32'(bus.req_ready), 32'd1);
    chk("mid rst f", bus.rsp_f, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("mid no rsp", 32'(seen), 32'd0);
    v = model(32'h1234_5678, 32'h1111_1111, 4'b1001,
              1'b0, 1'b1, 2'd3);
    v.nm = "post_rst";
    chk("post_rst model f", v.ef, 32'h2345_6789);
    run_op(v, 0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      v = model($urandom, $urandom, 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)));
      run_op(v, $urandom_range(0, 2), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
